// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: load funct3 codes, major opcodes used by decode,
// and the write-back stage state encoding.
package rv32i_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [0:0] {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: picks the byte/half out of a word-aligned
// read, extends it per funct3, and flags illegal or misaligned accesses.
module load_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data,
  output logic        o_err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  // Error cases return zero data; the write itself still happens upstream.
  always_comb begin
    o_data = 32'h0;
    o_err  = 1'b0;
    case (i_funct3)
      F3_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU: o_data = {24'h0, w_byte};
      F3_LH: begin
        if (i_addr_lo[0]) o_err = 1'b1;
        else              o_data = {{16{w_half[15]}}, w_half};
      end
      F3_LHU: begin
        if (i_addr_lo[0]) o_err = 1'b1;
        else              o_data = {16'h0, w_half};
      end
      F3_LW: begin
        if (i_addr_lo != 2'b00) o_err = 1'b1;
        else                    o_data = i_rdata;
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// RV32I write-back stage: retires ALU results in one cycle, parks loads until
// memory data returns, and drives the single register-file write port.
module writeback
  import rv32i_pkg::*;
#(
  parameter int INSTRET_W = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_e_valid,
  input  logic [31:0]          i_e_pc,
  input  logic [4:0]           i_e_rd,
  input  logic [31:0]          i_e_result,
  input  logic                 i_e_is_load,
  input  logic [2:0]           i_e_funct3,
  input  logic [1:0]           i_e_addr_lo,
  input  logic                 i_mem_rvalid,
  input  logic [31:0]          i_mem_rdata,
  output logic                 o_stall,
  output logic                 o_reg_we,
  output logic [4:0]           o_reg_wa,
  output logic [31:0]          o_reg_wd,
  output logic                 o_w_valid,
  output logic [31:0]          o_w_pc,
  output logic [INSTRET_W-1:0] o_instret,
  output logic                 o_load_err
);

  localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  wb_state_e             r_state;
  logic [31:0]           r_ld_pc;
  logic [4:0]            r_ld_rd;
  logic [2:0]            r_ld_funct3;
  logic [1:0]            r_ld_addr_lo;
  logic                  r_reg_we;
  logic [4:0]            r_reg_wa;
  logic [31:0]           r_reg_wd;
  logic                  r_w_valid;
  logic [31:0]           r_w_pc;
  logic [INSTRET_W-1:0]  r_instret;
  logic                  r_load_err;

  logic [31:0]           w_align_data;
  logic                  w_align_err;

  load_align u_load_align (
    .i_funct3  (r_ld_funct3),
    .i_addr_lo (r_ld_addr_lo),
    .i_rdata   (i_mem_rdata),
    .o_data    (w_align_data),
    .o_err     (w_align_err)
  );

  // Stall depends on state alone so upstream never sees a combinational loop.
  assign o_stall = (r_state == WB_WAIT_LOAD);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= WB_IDLE;
      r_ld_pc      <= 32'h0;
      r_ld_rd      <= 5'd0;
      r_ld_funct3  <= 3'b000;
      r_ld_addr_lo <= 2'b00;
      r_reg_we     <= 1'b0;
      r_reg_wa     <= 5'd0;
      r_reg_wd     <= 32'h0;
      r_w_valid    <= 1'b0;
      r_w_pc       <= 32'h0;
      r_instret    <= '0;
      r_load_err   <= 1'b0;
    end else begin
      r_reg_we  <= 1'b0;
      r_w_valid <= 1'b0;
      r_w_pc    <= 32'h0;
      case (r_state)
        WB_IDLE: begin
          if (i_e_valid) begin
            if (i_e_is_load) begin
              r_ld_pc      <= i_e_pc;
              r_ld_rd      <= i_e_rd;
              r_ld_funct3  <= i_e_funct3;
              r_ld_addr_lo <= i_e_addr_lo;
              r_state      <= WB_WAIT_LOAD;
            end else begin
              r_w_valid <= 1'b1;
              r_w_pc    <= i_e_pc;
              r_reg_wa  <= i_e_rd;
              r_reg_wd  <= i_e_result;
              r_reg_we  <= (i_e_rd != 5'd0);
              r_instret <= r_instret + INSTRET_ONE;
            end
          end
        end
        WB_WAIT_LOAD: begin
          if (i_mem_rvalid) begin
            r_w_valid  <= 1'b1;
            r_w_pc     <= r_ld_pc;
            r_reg_wa   <= r_ld_rd;
            r_reg_wd   <= w_align_data;
            r_reg_we   <= (r_ld_rd != 5'd0);
            r_instret  <= r_instret + INSTRET_ONE;
            r_load_err <= r_load_err | w_align_err;
            r_state    <= WB_IDLE;
          end
        end
        default: r_state <= WB_IDLE;
      endcase
    end
  end

  assign o_reg_we   = r_reg_we;
  assign o_reg_wa   = r_reg_wa;
  assign o_reg_wd   = r_reg_wd;
  assign o_w_valid  = r_w_valid;
  assign o_w_pc     = r_w_pc;
  assign o_instret  = r_instret;
  assign o_load_err = r_load_err;

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: the driver predicts retirements from a
// behavioural model and queues them; a negedge monitor pops and compares.
module tb_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        e_valid = 1'b0;
  logic [31:0] e_pc = 32'h0;
  logic [4:0]  e_rd = 5'd0;
  logic [31:0] e_result = 32'h0;
  logic        e_is_load = 1'b0;
  logic [2:0]  e_funct3 = 3'b000;
  logic [1:0]  e_addr_lo = 2'b00;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  logic        o_stall;
  logic        o_reg_we;
  logic [4:0]  o_reg_wa;
  logic [31:0] o_reg_wd;
  logic        o_w_valid;
  logic [31:0] o_w_pc;
  logic [63:0] o_instret;
  logic        o_load_err;

  writeback #(.INSTRET_W(64)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_e_valid    (e_valid),
    .i_e_pc       (e_pc),
    .i_e_rd       (e_rd),
    .i_e_result   (e_result),
    .i_e_is_load  (e_is_load),
    .i_e_funct3   (e_funct3),
    .i_e_addr_lo  (e_addr_lo),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata),
    .o_stall      (o_stall),
    .o_reg_we     (o_reg_we),
    .o_reg_wa     (o_reg_wa),
    .o_reg_wd     (o_reg_wd),
    .o_w_valid    (o_w_valid),
    .o_w_pc       (o_w_pc),
    .o_instret    (o_instret),
    .o_load_err   (o_load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [63:0] instret;
    logic        err;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  bit          modelWaiting = 1'b0;
  logic [31:0] ldPc;
  logic [4:0]  ldRd;
  logic [2:0]  ldF3;
  logic [1:0]  ldLo;
  logic [63:0] modelInstret = 64'd0;
  logic        modelErr = 1'b0;
  bit          lastAccepted;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference load semantics written as plain shift/mask arithmetic.
  function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [1:0] lo,
                                          input logic [31:0] w, output logic err);
    int unsigned sh, b, h, res;
    sh  = w >> (8 * lo);
    b   = sh & 32'hFF;
    h   = sh & 32'hFFFF;
    err = 1'b0;
    res = 0;
    case (f3)
      3'b000: res = (b >= 128) ? b - 256 : b;
      3'b100: res = b;
      3'b001: if (lo % 2 != 0) err = 1'b1; else res = (h >= 32768) ? h - 65536 : h;
      3'b101: if (lo % 2 != 0) err = 1'b1; else res = h;
      3'b010: if (lo != 0) err = 1'b1; else res = w;
      default: err = 1'b1;
    endcase
    return res;
  endfunction

  task automatic retire(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] wd);
    exp_t e;
    modelInstret = modelInstret + 64'd1;
    e.we = (rd != 5'd0);
    e.wa = rd;
    e.wd = wd;
    e.pc = pc;
    e.instret = modelInstret;
    e.err = modelErr;
    expQ.push_back(e);
  endtask

  task automatic stepCycle();
    logic [31:0] val;
    logic        err;
    checkOutput("stall", {63'd0, o_stall}, {63'd0, modelWaiting});
    @(posedge clk);
    lastAccepted = 1'b0;
    if (modelWaiting) begin
      if (mem_rvalid) begin
        val = refLoad(ldF3, ldLo, mem_rdata, err);
        if (err) modelErr = 1'b1;
        retire(ldPc, ldRd, val);
        modelWaiting = 1'b0;
      end
    end else if (e_valid) begin
      lastAccepted = 1'b1;
      if (e_is_load) begin
        ldPc = e_pc; ldRd = e_rd; ldF3 = e_funct3; ldLo = e_addr_lo;
        modelWaiting = 1'b1;
      end else begin
        retire(e_pc, e_rd, e_result);
      end
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic ld, input logic [31:0] pc,
                               input logic [4:0] rd, input logic [31:0] res,
                               input logic [2:0] f3, input logic [1:0] lo,
                               input logic rv, input logic [31:0] rdata);
    e_valid = v; e_is_load = ld; e_pc = pc; e_rd = rd; e_result = res;
    e_funct3 = f3; e_addr_lo = lo; mem_rvalid = rv; mem_rdata = rdata;
    stepCycle();
  endtask

  task automatic aluOp(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] res,
                       input logic rv);
    applyStimulus(1'b1, 1'b0, pc, rd, res, 3'b000, 2'b00, rv, $urandom);
  endtask

  task automatic loadOp(input logic [31:0] pc, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [1:0] lo);
    applyStimulus(1'b1, 1'b1, pc, rd, $urandom, f3, lo, 1'b0, 32'h0);
  endtask

  task automatic idleOp(input logic rv, input logic [31:0] rdata);
    applyStimulus(1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 3'b000, 2'b00, rv, rdata);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (o_w_valid) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_retire actual pc=%0h wa=%0d required none", o_w_pc, o_reg_wa);
        end else begin
          e = expQ.pop_front();
          checkOutput("reg_we", {63'd0, o_reg_we}, {63'd0, e.we});
          checkOutput("reg_wa", {59'd0, o_reg_wa}, {59'd0, e.wa});
          checkOutput("reg_wd", {32'd0, o_reg_wd}, {32'd0, e.wd});
          checkOutput("w_pc", {32'd0, o_w_pc}, {32'd0, e.pc});
          checkOutput("instret", o_instret, e.instret);
          checkOutput("load_err", {63'd0, o_load_err}, {63'd0, e.err});
        end
      end else begin
        checkOutput("reg_we_idle", {63'd0, o_reg_we}, 64'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_stall", {63'd0, o_stall}, 64'd0);
    checkOutput("rst_reg_we", {63'd0, o_reg_we}, 64'd0);
    checkOutput("rst_w_valid", {63'd0, o_w_valid}, 64'd0);
    checkOutput("rst_reg_wa", {59'd0, o_reg_wa}, 64'd0);
    checkOutput("rst_reg_wd", {32'd0, o_reg_wd}, 64'd0);
    checkOutput("rst_w_pc", {32'd0, o_w_pc}, 64'd0);
    checkOutput("rst_instret", o_instret, 64'd0);
    checkOutput("rst_load_err", {63'd0, o_load_err}, 64'd0);
    rst_n = 1'b1;

    aluOp(32'h100, 5'd5, 32'h12345678, 1'b0);
    checkOutput("alu_wd", {32'd0, o_reg_wd}, 64'h12345678);
    checkOutput("alu_instret", o_instret, 64'd1);
    aluOp(32'h104, 5'd0, 32'hFFFFFFFF, 1'b0);
    checkOutput("rd0_we", {63'd0, o_reg_we}, 64'd0);
    checkOutput("rd0_instret", o_instret, 64'd2);
    idleOp(1'b1, 32'hFFFFFFFF);

    // LB from byte lane 2 with the data returning three cycles later.
    loadOp(32'h108, 5'd7, 3'b000, 2'd2);
    repeat (3) idleOp(1'b0, 32'h0);
    idleOp(1'b1, 32'h00800000);
    checkOutput("lb_wd", {32'd0, o_reg_wd}, 64'hFFFFFF80);
    checkOutput("lb_stall_after", {63'd0, o_stall}, 64'd0);

    loadOp(32'h10C, 5'd9, 3'b101, 2'd1);
    idleOp(1'b1, 32'hFFFFFFFF);
    checkOutput("lhu_mis_wd", {32'd0, o_reg_wd}, 64'd0);
    checkOutput("lhu_mis_err", {63'd0, o_load_err}, 64'd1);
    for (int i = 0; i < 10; i++) aluOp(32'h200 + 4 * i, 5'($urandom_range(1, 31)), $urandom, 1'b0);
    idleOp(1'b0, 32'h0);
    checkOutput("err_sticky", {63'd0, o_load_err}, 64'd1);

    // Reset lands while a load is outstanding.
    loadOp(32'h300, 5'd3, 3'b010, 2'd0);
    idleOp(1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_stall", {63'd0, o_stall}, 64'd0);
    checkOutput("midrst_reg_we", {63'd0, o_reg_we}, 64'd0);
    checkOutput("midrst_instret", o_instret, 64'd0);
    checkOutput("midrst_load_err", {63'd0, o_load_err}, 64'd0);
    modelWaiting = 1'b0;
    modelInstret = 64'd0;
    modelErr = 1'b0;
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idleOp(1'b1, 32'hCAFEF00D);
    idleOp(1'b0, 32'h0);
    checkOutput("postrst_instret", o_instret, 64'd0);

    // Back-to-back ALU ops, a load, and an ALU op held across the stall.
    for (int i = 0; i < 4; i++) aluOp(32'h400 + 4 * i, 5'(i + 1), 32'h1000 + i, 1'b0);
    loadOp(32'h410, 5'd10, 3'b010, 2'd0);
    aluOp(32'h414, 5'd11, 32'hABCD, 1'b0);
    aluOp(32'h414, 5'd11, 32'hABCD, 1'b0);
    aluOp(32'h414, 5'd11, 32'hABCD, 1'b1);
    aluOp(32'h414, 5'd11, 32'hABCD, 1'b0);
    checkOutput("b2b_held_alu_wd", {32'd0, o_reg_wd}, 64'hABCD);
    idleOp(1'b0, 32'h0);
    checkOutput("b2b_instret", o_instret, 64'd6);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 3),
                    $urandom, 5'($urandom), $urandom, 3'($urandom), 2'($urandom),
                    1'($urandom_range(0, 9) < 4), $urandom);
    end
    for (int i = 0; i < 4 && modelWaiting; i++) idleOp(1'b1, $urandom);
    repeat (2) idleOp(1'b0, 32'h0);
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback.md
Name: writeback

Overview:
- RV32I write-back stage. It is the write side of the integer register file that the decode stage reads.
- Accepts completed instructions from execute/memory and waits for load data when needed.
- Aligns and extends load data, then drives the single register-file write port (x1..x31).
- Also maintains a retired-instruction counter and a sticky error flag for illegal or misaligned loads.

Parameters:
INSTRET_W, 64, width of retired-instruction counter

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous active-low reset (0 = reset)
E_VALID  in  1  execute presents a completed instruction
E_PC  in  32  PC of presented instruction
E_RD  in  5  destination register index
E_RESULT  in  32  ALU/jump-link result (ignored for loads)
E_IS_LOAD  in  1  instruction is a load
E_FUNCT3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
E_ADDR_LO  in  2  load effective address bits [1:0]
MEM_RVALID  in  1  load data valid, single-cycle pulse
MEM_RDATA  in  32  word-aligned load data
STALL  out  1  upstream must hold E_* (waiting for load data)
REG_WE  out  1  register-file write enable
REG_WA  out  5  write address
REG_WD  out  32  write data
W_VALID  out  1  instruction retired this cycle
W_PC  out  32  PC of retired instruction
INSTRET  out  INSTRET_W  count of retired instructions
LOAD_ERR  out  1  sticky: illegal funct3 or misaligned load seen

Behaviour:
- Reset (RST=0, async):
  - state=IDLE.
  - STALL, REG_WE, W_VALID, LOAD_ERR = 0.
  - REG_WA=0, REG_WD=0, W_PC=0, INSTRET=0.
  - A reset during WAIT_LOAD discards the pending load; no write occurs.
- Accept rule: E_* is sampled on a rising edge with E_VALID=1 and STALL=0.
- STALL = (state==WAIT_LOAD). It is a combinational decode of state only. It has no path from E_VALID or MEM_RVALID.
- FSM IDLE:
  - Accept of a non-load: next cycle W_VALID=1, W_PC=E_PC, REG_WA=E_RD, REG_WD=E_RESULT, REG_WE=(E_RD!=0). State stays IDLE. Latency is 1 cycle, and back-to-back accepts give back-to-back writes.
  - Accept of a load: latch E_PC, E_RD, E_FUNCT3, E_ADDR_LO, go to WAIT_LOAD. W_VALID=0 next cycle.
  - MEM_RVALID in IDLE is ignored.
- FSM WAIT_LOAD:
  - Without MEM_RVALID: hold state, no write.
  - On MEM_RVALID=1: next cycle W_VALID=1, REG_WE=(rd!=0), REG_WD=aligned data, state=IDLE. STALL is therefore 0 in the write cycle, so a new instruction can be accepted in that same cycle.
  - MEM_RVALID arriving in the same cycle the load is accepted is not used; data must arrive in a later cycle.
- Load alignment:
  - byte = RDATA[8*lo+7 : 8*lo]
  - half = lo[1] ? RDATA[31:16] : RDATA[15:0]
  - LB sign-extends byte; LBU zero-extends byte.
  - LH sign-extends half; LHU zero-extends half.
  - LW passes RDATA unchanged.
- Error cases (funct3 in {011,110,111}; LH/LHU with lo[0]=1; LW with lo!=0):
  - REG_WD=0, write still performed if rd!=0.
  - LOAD_ERR set to 1 and held until reset.
- REG_WE, W_VALID and W_PC are single-cycle pulses per retirement.
- INSTRET increments by 1 in each W_VALID cycle, including rd=0 instructions. It wraps from all-ones to 0.
- x0 is never written: REG_WE=0 whenever the write address is 0.

Decomposition:
- Shared package rv32i_pkg holds:
  - load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU)
  - opcode constants shared with decode
  - state encoding (WB_IDLE, WB_WAIT_LOAD)
- One natural sub-module: load_align (combinational). Inputs funct3, addr_lo, rdata; outputs data and err.

Test Plan:
- ALU accept: E_RD=5, E_RESULT=0x12345678, E_PC=0x100 -> next cycle REG_WE=1, REG_WA=5, REG_WD=0x12345678, W_PC=0x100, INSTRET=1.
- rd=0 accept: E_RD=0, E_RESULT=0xFFFFFFFF -> W_VALID=1, REG_WE=0, INSTRET increments.
- LB, E_ADDR_LO=2, E_RD=7; MEM_RVALID 3 cycles later with RDATA=0x00800000 -> STALL=1 for those cycles, then REG_WD=0xFFFFFF80, REG_WE=1, REG_WA=7, STALL=0.
- LHU, E_ADDR_LO=1 -> after MEM_RVALID: REG_WD=0, LOAD_ERR=1, and LOAD_ERR stays 1 across 10 further valid instructions.
- Load accepted, then RST=0 asserted mid-wait before MEM_RVALID -> STALL=0, REG_WE=0, INSTRET=0 immediately; a MEM_RVALID after reset release causes no write.
- Back-to-back: 4 ALU instructions on consecutive cycles, then a load, then an ALU instruction held during STALL -> 4 consecutive writes, the load write, then the ALU write in the cycle after the load write, INSTRET=6.
